// File: rtl/io_cu_pkg.sv
// io_cu_pkg: opcode constants, opcode field position, state encodings and
// the packed control-strobe bundle shared by the io_control_unit slice.
package io_cu_pkg;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

  localparam logic [OPC_W-1:0] OPC_IN   = 5'b10110;
  localparam logic [OPC_W-1:0] OPC_OUT  = 5'b10111;
  localparam logic [OPC_W-1:0] OPC_NOP  = 5'b11010;
  localparam logic [OPC_W-1:0] OPC_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_RST      = 4'd0,
    S_F0       = 4'd1,
    S_F1       = 4'd2,
    S_F2       = 4'd3,
    S_DEC      = 4'd4,
    S_IN_WAIT  = 4'd5,
    S_IN_XFER  = 4'd6,
    S_OUT_XFER = 4'd7,
    S_HALTED   = 4'd8
  } state_e;

  // One-hot instruction class produced by the decoder.
  typedef struct packed {
    logic is_in;
    logic is_out;
    logic is_halt;
    logic is_other;
  } iclass_t;

  // Every DataPath strobe plus the input-port acknowledge.
  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic inc_pc;
    logic zlow_in;
    logic zlow_out;
    logic pc_in;
    logic read;
    logic md_read;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic gra;
    logic r_in;
    logic r_out;
    logic inport_out;
    logic outport_in;
    logic in_ack;
  } ctrl_t;

  // Extract the opcode field from an instruction word.
  function automatic logic [OPC_W-1:0] opcode_of(input logic [31:0] ir);
    return ir[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/io_control_unit_if.sv
// io_control_unit_if: instruction word and input-port handshake between the
// DataPath / port source (master) and the control unit (slave).
interface io_control_unit_if;

  logic [31:0] IR;
  logic        in_valid;
  logic        in_ack;

  modport master (
    output IR,
    output in_valid,
    input  in_ack
  );

  modport slave (
    input  IR,
    input  in_valid,
    output in_ack
  );

endinterface

// File: rtl/io_cu_decode.sv
// io_cu_decode: combinational opcode -> one-hot instruction class.
// nop and every unrecognised opcode fall into the "other" class.
module io_cu_decode
  import io_cu_pkg::*;
#(
  parameter logic [4:0] P_OPC_IN   = 5'b10110,
  parameter logic [4:0] P_OPC_OUT  = 5'b10111,
  parameter logic [4:0] P_OPC_HALT = 5'b11011
) (
  input  logic [OPC_W-1:0] opcode,
  output iclass_t          iclass
);

  // Classify the opcode; exactly one class bit is high.
  always_comb begin
    iclass = '0;
    if (opcode == P_OPC_IN) begin
      iclass.is_in = 1'b1;
    end else if (opcode == P_OPC_OUT) begin
      iclass.is_out = 1'b1;
    end else if (opcode == P_OPC_HALT) begin
      iclass.is_halt = 1'b1;
    end else begin
      iclass.is_other = 1'b1;
    end
  end

endmodule

// File: rtl/io_control_unit.sv
// io_control_unit: Moore control sequencer for fetch/decode and the in, out,
// nop and halt instructions. Outputs are registered from the next state, so
// each strobe is high for exactly the cycle its state occupies.
// Optional feature macro: IO_CU_TIMEOUT_EN (bounded IN_WAIT with sticky
// io_timeout flag). Without it IN_WAIT waits indefinitely.
module io_control_unit #(
  parameter int         IN_TIMEOUT = 16,
  parameter logic [4:0] OPC_IN     = 5'b10110,
  parameter logic [4:0] OPC_OUT    = 5'b10111,
  parameter logic [4:0] OPC_NOP    = 5'b11010,
  parameter logic [4:0] OPC_HALT   = 5'b11011
) (
  input  logic                clock,
  input  logic                clear,
  io_control_unit_if.slave    bus,
  output logic                PCout,
  output logic                MARin,
  output logic                IncPC,
  output logic                Zlowin,
  output logic                Zlowout,
  output logic                PCin,
  output logic                Read,
  output logic                MD_read,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Gra,
  output logic                Rin,
  output logic                Rout,
  output logic                InPortout,
  output logic                Out_Portin,
  output logic                run,
  output logic                io_timeout
);
  import io_cu_pkg::*;

  state_e  state_q, state_d;
  ctrl_t   ctrl_q, ctrl_d;
  logic    run_q, run_d;
  iclass_t iclass_s;

  // nop needs no dedicated decode: it is handled like any other opcode.
  localparam logic [4:0] NOP_CODE = OPC_NOP;

`ifdef IO_CU_TIMEOUT_EN
  localparam int CW = $clog2(IN_TIMEOUT + 1);
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          timeout_q, timeout_d;
  logic          timeout_hit_s;
`endif

  io_cu_decode #(
    .P_OPC_IN   (OPC_IN),
    .P_OPC_OUT  (OPC_OUT),
    .P_OPC_HALT (OPC_HALT)
  ) u_decode (
    .opcode (opcode_of(bus.IR)),
    .iclass (iclass_s)
  );

  // State, output and (optional) timeout registers with synchronous clear.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= S_RST;
      ctrl_q  <= '0;
      run_q   <= 1'b0;
`ifdef IO_CU_TIMEOUT_EN
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      run_q   <= run_d;
`ifdef IO_CU_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  // Next-state logic; IR is only consulted in DEC.
  always_comb begin
    state_d = state_q;
`ifdef IO_CU_TIMEOUT_EN
    timeout_hit_s = 1'b0;
`endif
    if (clear) begin
      state_d = S_RST;
    end else begin
      case (state_q)
        S_RST:  state_d = S_F0;
        S_F0:   state_d = S_F1;
        S_F1:   state_d = S_F2;
        S_F2:   state_d = S_DEC;
        S_DEC: begin
          if (iclass_s.is_in) begin
            state_d = S_IN_WAIT;
          end else if (iclass_s.is_out) begin
            state_d = S_OUT_XFER;
          end else if (iclass_s.is_halt) begin
            state_d = S_HALTED;
          end else begin
            state_d = S_F0;
          end
        end
        S_IN_WAIT: begin
          if (bus.in_valid) begin
            state_d = S_IN_XFER;
`ifdef IO_CU_TIMEOUT_EN
          end else if (wait_cnt_q == CW'(IN_TIMEOUT - 1)) begin
            state_d       = S_IN_XFER;
            timeout_hit_s = 1'b1;
`endif
          end else begin
            state_d = S_IN_WAIT;
          end
        end
        S_IN_XFER:  state_d = S_F0;
        S_OUT_XFER: state_d = S_F0;
        S_HALTED:   state_d = S_HALTED;
        default:    state_d = S_RST;
      endcase
    end
  end

`ifdef IO_CU_TIMEOUT_EN
  // Wait counter: counts IN_WAIT cycles, saturates, clears on exit; sticky flag.
  always_comb begin
    wait_cnt_d = '0;
    if (!clear && state_q == S_IN_WAIT && state_d == S_IN_WAIT) begin
      if (wait_cnt_q != CW'(IN_TIMEOUT)) begin
        wait_cnt_d = wait_cnt_q + CW'(1);
      end else begin
        wait_cnt_d = wait_cnt_q;
      end
    end else begin
      wait_cnt_d = '0;
    end
    if (clear) begin
      timeout_d = 1'b0;
    end else begin
      timeout_d = timeout_q | timeout_hit_s;
    end
  end
`endif

  // Output decode of the upcoming state, so registered strobes align with it.
  always_comb begin
    ctrl_d = '0;
    run_d  = (state_d != S_HALTED) && (state_d != S_RST);
    case (state_d)
      S_F0: begin
        ctrl_d.pc_out  = 1'b1;
        ctrl_d.mar_in  = 1'b1;
        ctrl_d.inc_pc  = 1'b1;
        ctrl_d.zlow_in = 1'b1;
      end
      S_F1: begin
        ctrl_d.zlow_out = 1'b1;
        ctrl_d.pc_in    = 1'b1;
        ctrl_d.read     = 1'b1;
        ctrl_d.md_read  = 1'b1;
        ctrl_d.mdr_in   = 1'b1;
      end
      S_F2: begin
        ctrl_d.mdr_out = 1'b1;
        ctrl_d.ir_in   = 1'b1;
      end
      S_IN_XFER: begin
        ctrl_d.inport_out = 1'b1;
        ctrl_d.gra        = 1'b1;
        ctrl_d.r_in       = 1'b1;
        ctrl_d.in_ack     = 1'b1;
      end
      S_OUT_XFER: begin
        ctrl_d.gra        = 1'b1;
        ctrl_d.r_out      = 1'b1;
        ctrl_d.outport_in = 1'b1;
      end
      default: ctrl_d = '0;
    endcase
  end

  assign PCout      = ctrl_q.pc_out;
  assign MARin      = ctrl_q.mar_in;
  assign IncPC      = ctrl_q.inc_pc;
  assign Zlowin     = ctrl_q.zlow_in;
  assign Zlowout    = ctrl_q.zlow_out;
  assign PCin       = ctrl_q.pc_in;
  assign Read       = ctrl_q.read;
  assign MD_read    = ctrl_q.md_read;
  assign MDRin      = ctrl_q.mdr_in;
  assign MDRout     = ctrl_q.mdr_out;
  assign IRin       = ctrl_q.ir_in;
  assign Gra        = ctrl_q.gra;
  assign Rin        = ctrl_q.r_in;
  assign Rout       = ctrl_q.r_out;
  assign InPortout  = ctrl_q.inport_out;
  assign Out_Portin = ctrl_q.outport_in;
  assign bus.in_ack = ctrl_q.in_ack;
  assign run        = run_q;
`ifdef IO_CU_TIMEOUT_EN
  assign io_timeout = timeout_q;
`else
  assign io_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_io_control_unit.sv
// tb_io_control_unit: directed sequence with a per-cycle scoreboard of
// expected states; outputs are sampled on the falling clock edge.
module tb_io_control_unit;
  import io_cu_pkg::*;

  typedef struct {
    state_e st;
    logic   to;
  } exp_t;

  logic clock;
  logic clear;
  logic PCout, MARin, IncPC, Zlowin, Zlowout, PCin, Read, MD_read, MDRin;
  logic MDRout, IRin, Gra, Rin, Rout, InPortout, Out_Portin, run, io_timeout;

  io_control_unit_if bus_if ();

  int   checks;
  int   failures;
  exp_t sb_q[$];
  logic exp_to;

  io_control_unit #(
    .IN_TIMEOUT (4)
  ) dut (
    .clock      (clock),
    .clear      (clear),
    .bus        (bus_if),
    .PCout      (PCout),
    .MARin      (MARin),
    .IncPC      (IncPC),
    .Zlowin     (Zlowin),
    .Zlowout    (Zlowout),
    .PCin       (PCin),
    .Read       (Read),
    .MD_read    (MD_read),
    .MDRin      (MDRin),
    .MDRout     (MDRout),
    .IRin       (IRin),
    .Gra        (Gra),
    .Rin        (Rin),
    .Rout       (Rout),
    .InPortout  (InPortout),
    .Out_Portin (Out_Portin),
    .run        (run),
    .io_timeout (io_timeout)
  );

  // Free-running clock, 10 time-unit period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected {17 strobes, run, io_timeout} for a state, from the output table.
  function automatic logic [18:0] exp_vec(input state_e st, input logic to);
    logic [16:0] v;
    v = 17'd0;
    case (st)
      S_F0:       begin v[16] = 1'b1; v[15] = 1'b1; v[14] = 1'b1; v[13] = 1'b1; end
      S_F1:       begin v[12] = 1'b1; v[11] = 1'b1; v[10] = 1'b1; v[9] = 1'b1; v[8] = 1'b1; end
      S_F2:       begin v[7] = 1'b1; v[6] = 1'b1; end
      S_IN_XFER:  begin v[2] = 1'b1; v[5] = 1'b1; v[4] = 1'b1; v[0] = 1'b1; end
      S_OUT_XFER: begin v[5] = 1'b1; v[3] = 1'b1; v[1] = 1'b1; end
      default:    v = 17'd0;
    endcase
    return {v, (st != S_HALTED && st != S_RST), to};
  endfunction

  // Push the expectation for the cycle after the next rising edge, then check it.
  task automatic cycle(input state_e st);
    exp_t        e;
    logic [18:0] obs;
    logic [18:0] expv;
    int          n_out;
    sb_q.push_back('{st: st, to: exp_to});
    @(negedge clock);
    e    = sb_q.pop_front();
    expv = exp_vec(e.st, e.to);
    obs  = {PCout, MARin, IncPC, Zlowin, Zlowout, PCin, Read, MD_read, MDRin,
            MDRout, IRin, Gra, Rin, Rout, InPortout, Out_Portin, bus_if.in_ack,
            run, io_timeout};
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL state_%s: observed=%b expected=%b", e.st.name(), obs, expv);
    end
    n_out = int'(PCout) + int'(Zlowout) + int'(MDRout) + int'(Rout) + int'(InPortout);
    checks++;
    assert (n_out <= 1) else begin
      failures++;
      $error("FAIL bus_drivers_%s: observed=%0d expected<=1", e.st.name(), n_out);
    end
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    exp_to          = 1'b0;
    clear           = 1'b1;
    bus_if.IR       = 32'h0000_0000;
    bus_if.in_valid = 1'b0;

    // Reset held two cycles, then release into fetch.
    cycle(S_RST);
    cycle(S_RST);
    clear = 1'b0;
    cycle(S_F0);

    // in: three idle wait cycles plus the one that sees in_valid.
    bus_if.IR = 32'hB080_0000;
    cycle(S_F1);
    cycle(S_F2);
    cycle(S_DEC);
    cycle(S_IN_WAIT);
    cycle(S_IN_WAIT);
    cycle(S_IN_WAIT);
    cycle(S_IN_WAIT);
    bus_if.in_valid = 1'b1;
    cycle(S_IN_XFER);
    bus_if.in_valid = 1'b0;
    cycle(S_F0);

    // in with data already valid on entry: single wait cycle.
    cycle(S_F1);
    cycle(S_F2);
    bus_if.in_valid = 1'b1;
    cycle(S_DEC);
    cycle(S_IN_WAIT);
    cycle(S_IN_XFER);
    bus_if.in_valid = 1'b0;
    cycle(S_F0);

    // out.
    bus_if.IR = 32'hB880_0000;
    cycle(S_F1);
    cycle(S_F2);
    cycle(S_DEC);
    cycle(S_OUT_XFER);
    cycle(S_F0);

    // nop and an unrecognised opcode both return to fetch.
    bus_if.IR = 32'hD000_0000;
    cycle(S_F1);
    cycle(S_F2);
    cycle(S_DEC);
    cycle(S_F0);
    bus_if.IR = 32'h0800_1234;
    cycle(S_F1);
    cycle(S_F2);
    cycle(S_DEC);
    cycle(S_F0);

    // halt: stays halted for 20 cycles, clear pulse restarts fetch.
    bus_if.IR = 32'hD800_0000;
    cycle(S_F1);
    cycle(S_F2);
    cycle(S_DEC);
    for (int i = 0; i < 20; i++) cycle(S_HALTED);
    clear = 1'b1;
    cycle(S_RST);
    clear = 1'b0;
    cycle(S_F0);

    // clear in the middle of IN_WAIT wins over a valid input.
    bus_if.IR = 32'hB080_0000;
    cycle(S_F1);
    cycle(S_F2);
    cycle(S_DEC);
    cycle(S_IN_WAIT);
    cycle(S_IN_WAIT);
    clear           = 1'b1;
    bus_if.in_valid = 1'b1;
    cycle(S_RST);
    clear           = 1'b0;
    bus_if.in_valid = 1'b0;
    cycle(S_F0);

`ifdef IO_CU_TIMEOUT_EN
    // Timeout of 4: forced transfer after four idle wait cycles, sticky flag.
    cycle(S_F1);
    cycle(S_F2);
    cycle(S_DEC);
    for (int i = 0; i < 4; i++) cycle(S_IN_WAIT);
    exp_to = 1'b1;
    cycle(S_IN_XFER);
    cycle(S_F0);
    bus_if.IR = 32'hD000_0000;
    cycle(S_F1);
    cycle(S_F2);
    cycle(S_DEC);
    cycle(S_F0);
    clear  = 1'b1;
    exp_to = 1'b0;
    cycle(S_RST);
    clear = 1'b0;
    cycle(S_F0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
